// File: rtl/l1_req_seq.sv
// L1 request sequencer: accepts one CPU request at a time, runs the tag
// lookup, issues a downstream request on misses or upgrades, waits for the
// downstream response with a timeout, and returns the CPU response.

package cache_pkg;

  // Sequencer states, also exported on req_curSt
  typedef enum logic [2:0] {
    REQ_IDLE       = 3'd0,
    REQ_LOOKUP     = 3'd1,
    REQ_SDREQ      = 3'd2,
    REQ_WAIT_SURSP = 3'd3,
    REQ_RSP_CURSP  = 3'd4
  } req_st_e;

  // Bit indices into the one-hot req_status vector
  localparam int unsigned READ_HIT   = 3;
  localparam int unsigned WRITE_HIT  = 2;
  localparam int unsigned READ_MISS  = 1;
  localparam int unsigned WRITE_MISS = 0;

  // MESI block states
  localparam logic [2:0] INVALID   = 3'd0;
  localparam logic [2:0] SHARED    = 3'd1;
  localparam logic [2:0] EXCLUSIVE = 3'd2;
  localparam logic [2:0] MODIFIED  = 3'd3;

  // Downstream request types
  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RDX = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;
  localparam logic [2:0] SDREQ_WB  = 3'd3;

  // Downstream response codes; only SNOOP and FETCH are legal completions
  localparam logic [2:0] SURSP_NONE  = 3'd0;
  localparam logic [2:0] SURSP_SNOOP = 3'd1;
  localparam logic [2:0] SURSP_FETCH = 3'd2;
  localparam logic [2:0] SURSP_ERR   = 3'd3;

endpackage

module l1_req_seq
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_vld,
  output logic              cpu_req_rdy,
  input  logic              cpu_req_wr,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic              lkup_hit,
  input  logic [2:0]        blk_curSt,
  input  logic [2:0]        init_sdreq,
  output logic [3:0]        req_status,
  output logic [2:0]        req_curSt,
  output logic              sdreq_vld,
  input  logic              sdreq_rdy,
  output logic [2:0]        sdreq_type,
  output logic [ADDR_W-1:0] sdreq_addr,
  input  logic              sursp_vld,
  input  logic [2:0]        sursp_rsp,
  output logic [2:0]        sursp_q,
  output logic              blk_wr_en,
  output logic              cpu_rsp_vld,
  input  logic              cpu_rsp_rdy,
  output logic              cpu_rsp_err
);

  localparam int unsigned CNT_W = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC - 1);

  req_st_e           r_state;
  req_st_e           w_nxt_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [3:0]        r_status;
  logic              r_sdreq_vld;
  logic [2:0]        r_sdreq_type;
  logic [2:0]        r_sursp_q;
  logic              r_blk_wr_en;
  logic              r_cpu_rsp_vld;
  logic              r_err;
  logic              r_req_rdy;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_lk_direct;
  logic              w_lk_sdreq;
  logic              w_sd_fire;
  logic              w_rsp_take;
  logic              w_bad_rsp;
  logic              w_timeout;
  logic              w_rsp_done;
  logic              w_enter_rsp;
  logic              w_err_nxt;
  logic [3:0]        w_status;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state logic and per-state handshake events
  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_lk_direct = 1'b0;
    w_lk_sdreq  = 1'b0;
    w_sd_fire   = 1'b0;
    w_rsp_take  = 1'b0;
    w_bad_rsp   = 1'b0;
    w_timeout   = 1'b0;
    w_rsp_done  = 1'b0;
    unique case (r_state)
      REQ_IDLE: begin
        if (cpu_req_vld) begin
          w_accept    = 1'b1;
          w_nxt_state = REQ_LOOKUP;
        end
      end
      REQ_LOOKUP: begin
        // A write hit on a SHARED block still needs an upgrade downstream
        if (lkup_hit && (!r_wr || (blk_curSt != SHARED))) begin
          w_lk_direct = 1'b1;
          w_nxt_state = REQ_RSP_CURSP;
        end else begin
          w_lk_sdreq  = 1'b1;
          w_nxt_state = REQ_SDREQ;
        end
      end
      REQ_SDREQ: begin
        if (sdreq_rdy) begin
          w_sd_fire   = 1'b1;
          w_nxt_state = REQ_WAIT_SURSP;
        end
      end
      REQ_WAIT_SURSP: begin
        // A response arriving in the timeout cycle takes priority
        if (sursp_vld) begin
          w_rsp_take  = 1'b1;
          w_bad_rsp   = (sursp_rsp != SURSP_SNOOP) && (sursp_rsp != SURSP_FETCH);
          w_nxt_state = REQ_RSP_CURSP;
        end else if (r_cnt == CNT_MAX) begin
          w_timeout   = 1'b1;
          w_nxt_state = REQ_RSP_CURSP;
        end
      end
      REQ_RSP_CURSP: begin
        if (cpu_rsp_rdy) begin
          w_rsp_done  = 1'b1;
          w_nxt_state = REQ_IDLE;
        end
      end
      default: begin
        w_nxt_state = REQ_IDLE;
      end
    endcase
  end

  // Lookup classification and response-entry error
  always_comb begin
    w_status             = 4'b0000;
    w_status[READ_HIT]   = lkup_hit & ~r_wr;
    w_status[WRITE_HIT]  = lkup_hit & r_wr;
    w_status[READ_MISS]  = ~lkup_hit & ~r_wr;
    w_status[WRITE_MISS] = ~lkup_hit & r_wr;
    w_enter_rsp          = w_lk_direct | w_rsp_take | w_timeout;
    w_err_nxt            = w_timeout | w_bad_rsp;
  end

  // Transaction datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_wr          <= 1'b0;
      r_status      <= 4'b0000;
      r_sdreq_vld   <= 1'b0;
      r_sdreq_type  <= SDREQ_RD;
      r_sursp_q     <= 3'd0;
      r_blk_wr_en   <= 1'b0;
      r_cpu_rsp_vld <= 1'b0;
      r_err         <= 1'b0;
      r_req_rdy     <= 1'b1;
      r_cnt         <= '0;
    end else begin
      r_blk_wr_en <= 1'b0;
      r_req_rdy   <= (w_nxt_state == REQ_IDLE);
      if (w_accept) begin
        r_addr <= cpu_req_addr;
        r_wr   <= cpu_req_wr;
      end
      if (r_state == REQ_LOOKUP) begin
        r_status <= w_status;
      end
      if (w_lk_sdreq) begin
        r_sdreq_vld  <= 1'b1;
        r_sdreq_type <= init_sdreq;
      end
      if (w_sd_fire) begin
        r_sdreq_vld <= 1'b0;
        r_cnt       <= '0;
      end
      if ((r_state == REQ_WAIT_SURSP) && !sursp_vld && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rsp_take) begin
        r_sursp_q <= sursp_rsp;
      end
      if (w_enter_rsp) begin
        r_cpu_rsp_vld <= 1'b1;
        r_blk_wr_en   <= ~w_err_nxt;
        r_err         <= w_err_nxt;
      end
      if (w_rsp_done) begin
        r_cpu_rsp_vld <= 1'b0;
        r_status      <= 4'b0000;
        r_err         <= 1'b0;
        r_cnt         <= '0;
      end
    end
  end

  assign cpu_req_rdy = r_req_rdy;
  assign req_curSt   = r_state;
  assign req_status  = r_status;
  assign sdreq_vld   = r_sdreq_vld;
  assign sdreq_type  = r_sdreq_type;
  assign sdreq_addr  = r_addr;
  assign sursp_q     = r_sursp_q;
  assign blk_wr_en   = r_blk_wr_en;
  assign cpu_rsp_vld = r_cpu_rsp_vld;
  assign cpu_rsp_err = r_err;

endmodule

// File: tb/tb_l1_req_seq.sv
// Directed bench for l1_req_seq: hit, upgrade, miss, timeout, error,
// response stall and reset-abort scenarios with hand-computed expectations.

module tb_l1_req_seq;
  import cache_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TO_CYC = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req_vld;
  logic              cpu_req_rdy;
  logic              cpu_req_wr;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              lkup_hit;
  logic [2:0]        blk_curSt;
  logic [2:0]        init_sdreq;
  logic [3:0]        req_status;
  logic [2:0]        req_curSt;
  logic              sdreq_vld;
  logic              sdreq_rdy;
  logic [2:0]        sdreq_type;
  logic [ADDR_W-1:0] sdreq_addr;
  logic              sursp_vld;
  logic [2:0]        sursp_rsp;
  logic [2:0]        sursp_q;
  logic              blk_wr_en;
  logic              cpu_rsp_vld;
  logic              cpu_rsp_rdy;
  logic              cpu_rsp_err;

  int n_chk  = 0;
  int n_fail = 0;

  // Every output at its reset value
  localparam logic [49:0] EXP_RST = {3'd0, 4'd0, 1'b0, SDREQ_RD, 32'd0, 3'd0,
                                     1'b0, 1'b0, 1'b0, 1'b1};
  logic [49:0] obs_rst;
  assign obs_rst = {req_curSt, req_status, sdreq_vld, sdreq_type, sdreq_addr,
                    sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err, cpu_req_rdy};

  l1_req_seq #(.ADDR_W(ADDR_W), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_vld(cpu_req_vld), .cpu_req_rdy(cpu_req_rdy),
    .cpu_req_wr(cpu_req_wr), .cpu_req_addr(cpu_req_addr),
    .lkup_hit(lkup_hit), .blk_curSt(blk_curSt), .init_sdreq(init_sdreq),
    .req_status(req_status), .req_curSt(req_curSt),
    .sdreq_vld(sdreq_vld), .sdreq_rdy(sdreq_rdy),
    .sdreq_type(sdreq_type), .sdreq_addr(sdreq_addr),
    .sursp_vld(sursp_vld), .sursp_rsp(sursp_rsp), .sursp_q(sursp_q),
    .blk_wr_en(blk_wr_en),
    .cpu_rsp_vld(cpu_rsp_vld), .cpu_rsp_rdy(cpu_rsp_rdy), .cpu_rsp_err(cpu_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE; returns one cycle later in LOOKUP
  task automatic send_req(input logic wr, input logic [ADDR_W-1:0] addr);
    cpu_req_vld  = 1'b1;
    cpu_req_wr   = wr;
    cpu_req_addr = addr;
    tick();
    cpu_req_vld  = 1'b0;
  endtask

  task automatic finish_rsp();
    cpu_rsp_rdy = 1'b1;
    tick();
    cpu_rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (obs_rst !== EXP_RST) begin
      n_fail++;
      $display("FAIL reset_values: got %h, required %h", obs_rst, EXP_RST);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (obs_rst !== EXP_RST) begin
      n_fail++;
      $display("FAIL reset_release: got %h, required %h", obs_rst, EXP_RST);
    end
  endtask

  task automatic test_read_hit();
    send_req(1'b0, 32'h1000_0040);
    lkup_hit  = 1'b1;
    blk_curSt = EXCLUSIVE;
    n_chk++;
    if ({req_curSt, cpu_req_rdy, cpu_rsp_vld, sdreq_vld} !== {REQ_LOOKUP, 3'b000}) begin
      n_fail++;
      $display("FAIL rh_lookup: st=%0d rdy=%b rsp=%b sdv=%b, required st=1 0/0/0",
               req_curSt, cpu_req_rdy, cpu_rsp_vld, sdreq_vld);
    end
    tick();
    n_chk++;
    if ({req_curSt, req_status, blk_wr_en, cpu_rsp_vld, cpu_rsp_err, sdreq_vld} !==
        {REQ_RSP_CURSP, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rh_rsp: st=%0d status=%b wr_en=%b rsp=%b err=%b sdv=%b, required 4 1000 1 1 0 0",
               req_curSt, req_status, blk_wr_en, cpu_rsp_vld, cpu_rsp_err, sdreq_vld);
    end
    finish_rsp();
    n_chk++;
    if ({req_curSt, req_status, blk_wr_en, cpu_rsp_vld, cpu_req_rdy} !==
        {REQ_IDLE, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rh_idle: st=%0d status=%b wr_en=%b rsp=%b rdy=%b, required 0 0000 0 0 1",
               req_curSt, req_status, blk_wr_en, cpu_rsp_vld, cpu_req_rdy);
    end
  endtask

  task automatic test_write_upgrade();
    int vld_cyc = 0;
    send_req(1'b1, 32'hA5A5_0100);
    lkup_hit   = 1'b1;
    blk_curSt  = SHARED;
    init_sdreq = SDREQ_INV;
    sdreq_rdy  = 1'b0;
    tick();
    init_sdreq = SDREQ_RD;
    for (int i = 0; i < 4; i++) begin
      if (sdreq_vld === 1'b1) vld_cyc++;
      n_chk++;
      if ({req_curSt, sdreq_vld, sdreq_type, sdreq_addr, req_status} !==
          {REQ_SDREQ, 1'b1, SDREQ_INV, 32'hA5A5_0100, 4'b0100}) begin
        n_fail++;
        $display("FAIL wu_sdreq[%0d]: st=%0d vld=%b type=%0d addr=%h status=%b, required 2 1 2 a5a50100 0100",
                 i, req_curSt, sdreq_vld, sdreq_type, sdreq_addr, req_status);
      end
      sdreq_rdy = (i == 3);
      tick();
    end
    sdreq_rdy = 1'b0;
    n_chk++;
    if ({req_curSt, sdreq_vld} !== {REQ_WAIT_SURSP, 1'b0} || vld_cyc != 4) begin
      n_fail++;
      $display("FAIL wu_wait: st=%0d vld=%b vld_cycles=%0d, required 3 0 4",
               req_curSt, sdreq_vld, vld_cyc);
    end
    sursp_vld = 1'b1;
    sursp_rsp = SURSP_SNOOP;
    tick();
    sursp_vld = 1'b0;
    n_chk++;
    if ({req_curSt, sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err} !==
        {REQ_RSP_CURSP, SURSP_SNOOP, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL wu_rsp: st=%0d q=%0d wr_en=%b rsp=%b err=%b, required 4 1 1 1 0",
               req_curSt, sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_read_miss();
    int pulses = 0;
    send_req(1'b0, 32'h0000_2000);
    lkup_hit   = 1'b0;
    init_sdreq = SDREQ_RD;
    sdreq_rdy  = 1'b1;
    tick();
    n_chk++;
    if ({req_curSt, req_status, sdreq_vld, sdreq_type} !==
        {REQ_SDREQ, 4'b0010, 1'b1, SDREQ_RD}) begin
      n_fail++;
      $display("FAIL rm_sdreq: st=%0d status=%b vld=%b type=%0d, required 2 0010 1 0",
               req_curSt, req_status, sdreq_vld, sdreq_type);
    end
    tick();
    sdreq_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (req_curSt !== REQ_WAIT_SURSP) begin
        n_fail++;
        $display("FAIL rm_wait[%0d]: st=%0d, required 3", i, req_curSt);
      end
      tick();
    end
    sursp_vld = 1'b1;
    sursp_rsp = SURSP_FETCH;
    tick();
    sursp_vld = 1'b0;
    if (blk_wr_en === 1'b1) pulses++;
    n_chk++;
    if ({req_curSt, sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err} !==
        {REQ_RSP_CURSP, SURSP_FETCH, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rm_rsp: st=%0d q=%0d wr_en=%b rsp=%b err=%b, required 4 2 1 1 0",
               req_curSt, sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err);
    end
    tick();
    if (blk_wr_en === 1'b1) pulses++;
    n_chk++;
    if ({req_curSt, cpu_rsp_vld} !== {REQ_RSP_CURSP, 1'b1} || pulses != 1) begin
      n_fail++;
      $display("FAIL rm_pulse: st=%0d rsp=%b pulses=%0d, required 4 1 1",
               req_curSt, cpu_rsp_vld, pulses);
    end
    finish_rsp();
  endtask

  task automatic test_timeout();
    int wait_cyc = 0;
    int seen_wr  = 0;
    send_req(1'b1, 32'h0000_3000);
    lkup_hit   = 1'b0;
    init_sdreq = SDREQ_RDX;
    sdreq_rdy  = 1'b1;
    tick();
    n_chk++;
    if ({req_status, sdreq_type} !== {4'b0001, SDREQ_RDX}) begin
      n_fail++;
      $display("FAIL to_sdreq: status=%b type=%0d, required 0001 1", req_status, sdreq_type);
    end
    tick();
    sdreq_rdy = 1'b0;
    while (req_curSt === REQ_WAIT_SURSP && wait_cyc < 20) begin
      wait_cyc++;
      if (blk_wr_en === 1'b1) seen_wr++;
      tick();
    end
    if (blk_wr_en === 1'b1) seen_wr++;
    n_chk++;
    if (wait_cyc != 8 || {req_curSt, cpu_rsp_vld, cpu_rsp_err, blk_wr_en} !==
        {REQ_RSP_CURSP, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL to_rsp: wait=%0d st=%0d rsp=%b err=%b wr_en=%b, required 8 4 1 1 0",
               wait_cyc, req_curSt, cpu_rsp_vld, cpu_rsp_err, blk_wr_en);
    end
    tick();
    if (blk_wr_en === 1'b1) seen_wr++;
    finish_rsp();
    n_chk++;
    if (seen_wr != 0 || {req_curSt, cpu_rsp_err} !== {REQ_IDLE, 1'b0}) begin
      n_fail++;
      $display("FAIL to_idle: wr_pulses=%0d st=%0d err=%b, required 0 0 0",
               seen_wr, req_curSt, cpu_rsp_err);
    end
  endtask

  task automatic test_timeout_race();
    send_req(1'b0, 32'h0000_4000);
    lkup_hit  = 1'b0;
    sdreq_rdy = 1'b1;
    tick();
    tick();
    sdreq_rdy = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_chk++;
    if (req_curSt !== REQ_WAIT_SURSP) begin
      n_fail++;
      $display("FAIL race_wait: st=%0d, required 3", req_curSt);
    end
    sursp_vld = 1'b1;
    sursp_rsp = SURSP_SNOOP;
    tick();
    sursp_vld = 1'b0;
    n_chk++;
    if ({req_curSt, sursp_q, blk_wr_en, cpu_rsp_err} !==
        {REQ_RSP_CURSP, SURSP_SNOOP, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL race_rsp: st=%0d q=%0d wr_en=%b err=%b, required 4 1 1 0",
               req_curSt, sursp_q, blk_wr_en, cpu_rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_bad_rsp();
    send_req(1'b0, 32'h0000_5000);
    lkup_hit  = 1'b0;
    sdreq_rdy = 1'b1;
    tick();
    tick();
    sdreq_rdy = 1'b0;
    sursp_vld = 1'b1;
    sursp_rsp = SURSP_ERR;
    tick();
    sursp_vld = 1'b0;
    n_chk++;
    if ({req_curSt, sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err} !==
        {REQ_RSP_CURSP, SURSP_ERR, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL bad_rsp: st=%0d q=%0d wr_en=%b rsp=%b err=%b, required 4 3 0 1 1",
               req_curSt, sursp_q, blk_wr_en, cpu_rsp_vld, cpu_rsp_err);
    end
    finish_rsp();
  endtask

  task automatic test_rsp_stall();
    int pulses = 0;
    send_req(1'b1, 32'h0000_6000);
    lkup_hit  = 1'b1;
    blk_curSt = MODIFIED;
    tick();
    n_chk++;
    if (req_status !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_status: got %b, required 0100", req_status);
    end
    cpu_req_vld  = 1'b1;
    cpu_req_addr = 32'h0000_7000;
    for (int i = 0; i < 4; i++) begin
      if (blk_wr_en === 1'b1) pulses++;
      n_chk++;
      if ({req_curSt, cpu_rsp_vld, cpu_req_rdy} !== {REQ_RSP_CURSP, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: st=%0d rsp=%b rdy=%b, required 4 1 0",
                 i, req_curSt, cpu_rsp_vld, cpu_req_rdy);
      end
      tick();
    end
    cpu_rsp_rdy = 1'b1;
    tick();
    cpu_rsp_rdy = 1'b0;
    cpu_req_vld = 1'b0;
    n_chk++;
    if (pulses != 1 || {req_curSt, cpu_rsp_vld} !== {REQ_IDLE, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_done: pulses=%0d st=%0d rsp=%b, required 1 0 0",
               pulses, req_curSt, cpu_rsp_vld);
    end
  endtask

  task automatic test_reset_abort();
    send_req(1'b0, 32'h0000_8000);
    lkup_hit  = 1'b0;
    sdreq_rdy = 1'b1;
    tick();
    tick();
    sdreq_rdy = 1'b0;
    n_chk++;
    if (req_curSt !== REQ_WAIT_SURSP) begin
      n_fail++;
      $display("FAIL abort_pre: st=%0d, required 3", req_curSt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (obs_rst !== EXP_RST) begin
      n_fail++;
      $display("FAIL abort_reset: got %h, required %h", obs_rst, EXP_RST);
    end
    sursp_vld = 1'b1;
    sursp_rsp = SURSP_FETCH;
    tick();
    sursp_vld = 1'b0;
    n_chk++;
    if (obs_rst !== EXP_RST) begin
      n_fail++;
      $display("FAIL abort_ignore: got %h, required %h", obs_rst, EXP_RST);
    end
  endtask

  initial begin
    rst          = 1'b1;
    cpu_req_vld  = 1'b0;
    cpu_req_wr   = 1'b0;
    cpu_req_addr = '0;
    lkup_hit     = 1'b0;
    blk_curSt    = INVALID;
    init_sdreq   = SDREQ_RD;
    sdreq_rdy    = 1'b0;
    sursp_vld    = 1'b0;
    sursp_rsp    = SURSP_NONE;
    cpu_rsp_rdy  = 1'b0;
    test_reset();
    test_read_hit();
    test_write_upgrade();
    test_read_miss();
    test_timeout();
    test_timeout_race();
    test_bad_rsp();
    test_rsp_stall();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
